// File: rtl/branch_ctrl_pkg.sv
// Shared types and funct3 encodings for the EX-stage branch controller.
package branch_ctrl_pkg;

  typedef logic [63:0] dw;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_e;

  function automatic logic is_misaligned(input dw target);
    return target[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/br_decide.sv
// Pure combinational branch condition decode: funct3 plus comparator flags to taken/unsigned/illegal.
module br_decide
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken,
  output logic       br_un,
  output logic       illegal
);

  assign br_un = (funct3 == F3_BLTU) || (funct3 == F3_BGEU);

  // Condition select from funct3; reserved encodings are flagged and never taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           taken = br_eq;
      F3_BNE:           taken = !br_eq;
      F3_BLT, F3_BLTU:  taken = br_lt;
      F3_BGE, F3_BGEU:  taken = !br_lt;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: redirect generation, flush FSM, exception pulses and perf counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [63:0]      ex_target,
  output logic             br_un,
  input  logic             br_eq,
  input  logic             br_lt,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_exc,
  output logic             illegal_br,
  output logic [CNT_W-1:0] perf_branch_cnt,
  output logic [CNT_W-1:0] perf_taken_cnt
);

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  br_state_e        state_r, state_nxt_s;
  logic [2:0]       flush_cnt_r, flush_cnt_nxt_s;
  logic             cond_taken_s, illegal_s;
  logic             is_cond_s, taken_s, accept_s;
  logic             do_redirect_s, do_misalign_s, do_illegal_s;
  dw                target_s;
  logic             redirect_valid_r, misalign_exc_r, illegal_br_r;
  dw                redirect_pc_r;
  logic [CNT_W-1:0] branch_cnt_r, taken_cnt_r;

  br_decide u_decide (
    .funct3  (ex_funct3),
    .br_eq   (br_eq),
    .br_lt   (br_lt),
    .taken   (cond_taken_s),
    .br_un   (br_un),
    .illegal (illegal_s)
  );

  assign accept_s = (state_r == BR_IDLE) && ex_valid && !stall;

  // Instruction classification with JALR > JAL > branch priority and JALR bit0 clear.
  always_comb begin
    is_cond_s = ex_is_branch && !ex_is_jal && !ex_is_jalr;
    if (ex_is_jalr) begin
      target_s = {ex_target[63:1], 1'b0};
    end else begin
      target_s = ex_target;
    end
    if (ex_is_jalr || ex_is_jal) begin
      taken_s = 1'b1;
    end else if (is_cond_s) begin
      taken_s = cond_taken_s;
    end else begin
      taken_s = 1'b0;
    end
    do_redirect_s = accept_s && taken_s && !is_misaligned(target_s);
    do_misalign_s = accept_s && taken_s && is_misaligned(target_s);
    do_illegal_s  = accept_s && is_cond_s && illegal_s;
  end

  // Flush FSM next state; counter only moves on non-stall cycles.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    case (state_r)
      BR_IDLE: begin
        if (do_redirect_s) begin
          state_nxt_s     = BR_FLUSH;
          flush_cnt_nxt_s = FLUSH_LOAD;
        end else begin
          state_nxt_s     = BR_IDLE;
        end
      end
      BR_FLUSH: begin
        if (stall) begin
          state_nxt_s     = BR_FLUSH;
        end else if (flush_cnt_r == 3'd1) begin
          state_nxt_s     = BR_IDLE;
          flush_cnt_nxt_s = 3'd0;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
        end
      end
      default: begin
        state_nxt_s     = BR_IDLE;
        flush_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // State, pulse outputs, redirect target and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= BR_IDLE;
      flush_cnt_r      <= 3'd0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 64'd0;
      misalign_exc_r   <= 1'b0;
      illegal_br_r     <= 1'b0;
      branch_cnt_r     <= '0;
      taken_cnt_r      <= '0;
    end else begin
      state_r          <= state_nxt_s;
      flush_cnt_r      <= flush_cnt_nxt_s;
      redirect_valid_r <= do_redirect_s;
      misalign_exc_r   <= do_misalign_s;
      illegal_br_r     <= do_illegal_s;
      if (do_redirect_s) begin
        redirect_pc_r <= target_s;
        taken_cnt_r   <= taken_cnt_r + CNT_ONE;
      end
      if (accept_s && is_cond_s) begin
        branch_cnt_r <= branch_cnt_r + CNT_ONE;
      end
    end
  end

  assign redirect_valid  = redirect_valid_r;
  assign redirect_pc     = redirect_pc_r;
  assign misalign_exc    = misalign_exc_r;
  assign illegal_br      = illegal_br_r;
  assign flush_if_id     = (state_r == BR_FLUSH);
  assign flush_id_ex     = (state_r == BR_FLUSH);
  assign perf_branch_cnt = branch_cnt_r;
  assign perf_taken_cnt  = taken_cnt_r;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- EX-stage branch resolution controller for the RV64I pipeline; drives the controller side of BranchCompControlIntf (BrUn out, BrEq/BrLt in).
- Decodes branch/jump funct3, selects signed/unsigned compare, decides taken/not-taken, checks target alignment.
- Issues a registered one-cycle PC redirect and holds IF/ID and ID/EX flush through a small flush FSM.
- Keeps branch/taken performance counters.

Parameters:
- FLUSH_CYCLES, 2, cycles the flush is held after a redirect (1..7)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline hold; freezes all state
- ex_valid  in  1  EX-stage instruction valid
- ex_is_branch  in  1  conditional branch (opcode BRANCH)
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_funct3  in  3  branch funct3
- ex_target  in  64  ALU-computed target (dw)
- br_un  out  1  BrUn to BranchCompControlIntf
- br_eq  in  1  BrEq from BranchCompControlIntf
- br_lt  in  1  BrLt from BranchCompControlIntf
- redirect_valid  out  1  one-cycle redirect pulse to IF
- redirect_pc  out  64  redirect target (dw)
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- misalign_exc  out  1  one-cycle instruction-address-misaligned pulse
- illegal_br  out  1  one-cycle illegal-funct3 pulse
- perf_branch_cnt  out  CNT_W  resolved conditional branches
- perf_taken_cnt  out  CNT_W  taken branches and jumps

Behaviour:
- br_un combinational: 1 iff ex_funct3 is 110 (BLTU) or 111 (BGEU); 0 otherwise.
- Taken, combinational: BEQ 000 = br_eq; BNE 001 = !br_eq; BLT 100 / BLTU 110 = br_lt; BGE 101 / BGEU 111 = !br_lt.
- funct3 010 or 011 with ex_is_branch: not taken, illegal_br pulses next cycle.
- JAL and JALR are always taken. For JALR, target bit0 is cleared before use.
- Accept condition: state IDLE, ex_valid=1, stall=0. Nothing is evaluated otherwise.
- Misaligned target (bits[1:0] != 0 after the JALR clear) when taken: no redirect; misalign_exc pulses next cycle; no flush.
- Redirect latency 1 cycle: on an accepted taken, aligned instruction:
  - next edge: redirect_valid=1 for exactly one cycle; redirect_pc=target.
  - state goes to FLUSH; flush counter loads FLUSH_CYCLES.
- FSM states:
  - IDLE: flush outputs 0.
  - FLUSH: flush_if_id=flush_id_ex=1. Counter decrements each non-stall cycle; return to IDLE when the cycle with counter=1 completes.
  - In FLUSH, ex_valid inputs are wrong-path: ignored, no counting.
- stall=1: state, counter and perf counters hold. Pulse outputs still clear after one cycle; a pending pulse is not re-issued.
- Counters: perf_branch_cnt increments per accepted conditional branch, including illegal funct3. perf_taken_cnt increments per accepted taken aligned instruction. Both wrap from all-ones to 0.
- Priority when ex_is_branch and a jump flag are set together: JALR > JAL > branch.
- Reset: all outputs and counters 0, redirect_pc=0, state IDLE. Reset mid-FLUSH aborts immediately.

Decomposition:
- DEF package:
  - dw typedef.
  - funct3 localparams F3_BEQ..F3_BGEU.
  - br_state_e enum {BR_IDLE, BR_FLUSH}.
- Optional sub-module br_decide: pure combinational funct3/br_eq/br_lt → taken/br_un/illegal. Everything else stays in branch_ctrl.

Test Plan:
- BEQ funct3=000, br_eq=1, target=0x1000 → br_un=0; next cycle redirect_valid=1, redirect_pc=0x1000; flushes high 2 cycles; perf_taken_cnt=1.
- BLTU funct3=110, br_lt=0 → br_un=1, no redirect, no flush; perf_branch_cnt=1, perf_taken_cnt=0.
- JALR target=0x2003 → misalign_exc pulses once, no redirect. JALR target=0x2001 → redirect_pc=0x2000.
- Taken BNE followed by ex_valid=1 BEQ taken during FLUSH → only first redirect; perf_branch_cnt=1.
- stall=1 asserted for 3 cycles in the middle of FLUSH → flush held 2+3 cycles; rst=1 mid-FLUSH → all outputs 0 next cycle.
- funct3=010 branch → illegal_br pulse, no redirect. Preload counter to all-ones (CNT_W=4, 15 taken branches, then 1 more) → perf_taken_cnt wraps to 0.
